unidade_multdiv: RTL
====================

# unidade_multdiv

Iterative 8-bit unsigned multiply/divide unit placed beside the ALU in the execute stage. It consumes the two register-bank read values and returns its result through the register-bank write port (EscreveReg / regEscrito / dadoEscrito) once the computation finishes. It handles the MUL, MULH, DIV and REM operations, which are too costly to perform combinationally in one cycle. The control unit stalls the program counter while `ocupado` is high.

## Interface
- WIDTH, 8, operand and result width
- REG_ADDR_W, 2, register address width (4 registers)
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- inicia  in  1  start request; sampled only in OCIOSO
- operacao  in  2  00 MUL (low byte), 01 MULH (high byte), 10 DIV (quotient), 11 REM (remainder)
- operandoA  in  WIDTH  multiplicand / dividend (register-bank out1)
- operandoB  in  WIDTH  multiplier / divisor (register-bank out2)
- regDestino  in  REG_ADDR_W  destination register
- ocupado  out  1  high from the accepting edge until the write edge
- pronto  out  1  one-cycle pulse: result valid
- EscreveReg  out  1  write enable to the register bank
- regEscrito  out  REG_ADDR_W  write address to the register bank
- dadoEscrito  out  WIDTH  write data to the register bank
- divZero  out  1  divisor-zero flag; valid while pronto is high

## Operation
- FSM states:
  - OCIOSO, CALCULA, ESCRITA.
  - OCIOSO→CALCULA when inicia=1. The unit latches operacao, operandoA, operandoB and regDestino, and clears the counter.
  - CALCULA→ESCRITA after the 8th iteration.
  - ESCRITA→OCIOSO unconditionally.
- DIV/REM with operandoB=0: OCIOSO→ESCRITA directly, with no iterations.
- All arithmetic is unsigned.
- MUL/MULH use shift-add: a 16-bit accumulator, one multiplier bit per cycle, LSB first.
  - MUL returns product[7:0].
  - MULH returns product[15:8].
- DIV/REM use restoring division: a 9-bit partial remainder, one quotient bit per cycle, MSB first.
- Divide by zero: DIV returns 0xFF, REM returns operandoA, and divZero=1. For every other result, divZero=0.
- inicia is ignored while ocupado=1. Input changes after acceptance have no effect.
- regDestino=0: the computation still runs and pronto still pulses, but EscreveReg stays 0. Register 0 is hard zero.
- Every output is registered.
  - dadoEscrito, regEscrito and divZero hold their last value until the next ESCRITA.
  - EscreveReg and pronto are high only in ESCRITA.
- Reset (reset_n=0, at any time, including mid-operation):
  - state becomes OCIOSO and the counter is 0;
  - ocupado, pronto, EscreveReg and divZero are 0;
  - regEscrito is 0 and dadoEscrito is 0x00;
  - no write is issued for the aborted operation.

## Timing
- Edge E0 samples inicia=1 in OCIOSO. ocupado is high after E0.
- Normal operations:
  - Edges E1..E8 each perform one iteration.
  - The state is ESCRITA from E8 to E9, and pronto, EscreveReg and the final dadoEscrito are visible in that window.
  - The register bank captures the result at E9, after which ocupado=0.
  - Total latency is 9 cycles from acceptance to the write edge.
- Divide by zero: ESCRITA lies between E0 and E1, and the write happens at E1.
- Back-to-back: inicia may be high at the edge where the state is OCIOSO after E9 (the earliest is E10). There is no acceptance at E9 itself.
- Reset is asynchronous on assertion. Release is synchronised externally to clock.

## Structure
- Shared package holds:
  - operation codes (OP_MUL, OP_MULH, OP_DIV, OP_REM);
  - the FSM state enum;
  - WIDTH and REG_ADDR_W defaults;
  - the iteration count constant (= WIDTH).
- One natural sub-module: `passo_multdiv`, a combinational single-iteration datapath. It takes the accumulator/remainder and the operand, returns the next value, and selects shift-add or restore-subtract by operation class.
- The FSM, counter and output registers live in `unidade_multdiv`.

## Test plan
- MUL 13×11 into reg 1 → at E9: EscreveReg=1, regEscrito=1, dadoEscrito=0x8F; pronto is one cycle wide; divZero=0.
- MULH 200×200 into reg 2 → dadoEscrito=0x9C (product 0x9C40). MUL with the same operands gives 0x40.
- DIV 200/7 into reg 3 → 0x1C. REM 200/7 → 0x04. Both take 9-cycle latency.
- DIV 0x2A/0 → pronto in the cycle after acceptance, dadoEscrito=0xFF, divZero=1. REM 0x2A/0 → 0x2A.
- MUL with regDestino=0 → pronto pulses, EscreveReg stays 0. inicia held high throughout is accepted only once per operation, with the next acceptance at E10.
- reset_n pulled low during cycle 4 of a DIV → all outputs 0 immediately, no pronto/EscreveReg. After release, a new MUL 3×5 returns 0x0F normally.

Source files
------------

// File: rtl/unidade_multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and default widths.
package unidade_multdiv_pkg;

  localparam int WIDTH_PADRAO      = 8;
  localparam int REG_ADDR_W_PADRAO = 2;
  localparam int N_ITERACOES       = WIDTH_PADRAO;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    ESCRITA = 2'd2
  } estado_e;

  // DIV and REM share the restoring-division datapath
  function automatic logic eh_divisao(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/passo_multdiv.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-division step, selected by operation class.
module passo_multdiv #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH:0] acc_atual,
  input  logic [WIDTH-1:0] operando,
  input  logic             divide,
  output logic [2*WIDTH:0] acc_prox
);

  logic [WIDTH:0]   soma_s;
  logic [WIDTH+1:0] resto_desl_s;
  logic [WIDTH+1:0] dif_s;

  // Divide: acc = {remainder, quotient}. Multiply: acc = {carry, high, multiplier}.
  always_comb begin
    soma_s       = {1'b0, acc_atual[2*WIDTH-1:WIDTH]} +
                   {1'b0, (acc_atual[0] ? operando : {WIDTH{1'b0}})};
    resto_desl_s = {1'b0, acc_atual[2*WIDTH:WIDTH-1]};
    dif_s        = resto_desl_s - {2'b00, operando};
    if (divide) begin
      if (dif_s[WIDTH+1] == 1'b0) begin
        acc_prox = {dif_s[WIDTH:0], acc_atual[WIDTH-2:0], 1'b1};
      end else begin
        acc_prox = {resto_desl_s[WIDTH:0], acc_atual[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_prox = {1'b0, soma_s, acc_atual[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/unidade_multdiv.sv
// Iterative unsigned 8-bit MUL/MULH/DIV/REM unit writing its result through
// the register-bank write port; FSM, iteration counter and output registers.
module unidade_multdiv
  import unidade_multdiv_pkg::*;
#(
  parameter int WIDTH      = WIDTH_PADRAO,
  parameter int REG_ADDR_W = REG_ADDR_W_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  inicia,
  input  logic [1:0]            operacao,
  input  logic [WIDTH-1:0]      operandoA,
  input  logic [WIDTH-1:0]      operandoB,
  input  logic [REG_ADDR_W-1:0] regDestino,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  EscreveReg,
  output logic [REG_ADDR_W-1:0] regEscrito,
  output logic [WIDTH-1:0]      dadoEscrito,
  output logic                  divZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  estado_e               estado_r, estado_s;
  logic [1:0]            op_r;
  logic [WIDTH-1:0]      opnd_r;
  logic [REG_ADDR_W-1:0] reg_r;
  logic [2*WIDTH:0]      acc_r, acc_prox_s;
  logic [CW-1:0]         cont_r;
  logic                  aceita_s, div_zero_in_s, ultima_s;
  logic [WIDTH-1:0]      resultado_s;

  logic                  ocupado_r, ocupado_s;
  logic                  pronto_r, pronto_s;
  logic                  escreve_r, escreve_s;
  logic [REG_ADDR_W-1:0] reg_esc_r, reg_esc_s;
  logic [WIDTH-1:0]      dado_r, dado_s;
  logic                  dz_r, dz_s;

  assign aceita_s      = (estado_r == OCIOSO) && inicia;
  assign div_zero_in_s = eh_divisao(operacao) && (operandoB == {WIDTH{1'b0}});
  assign ultima_s      = (cont_r == CW'(WIDTH - 1));
  assign resultado_s   = op_r[0] ? acc_prox_s[2*WIDTH-1:WIDTH] : acc_prox_s[WIDTH-1:0];

  passo_multdiv #(.WIDTH(WIDTH)) u_passo (
    .acc_atual (acc_r),
    .operando  (opnd_r),
    .divide    (eh_divisao(op_r)),
    .acc_prox  (acc_prox_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado_r <= OCIOSO;
    else          estado_r <= estado_s;
  end

  // Next-state logic; division by zero skips the iterations entirely
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (aceita_s) estado_s = div_zero_in_s ? ESCRITA : CALCULA;
        else          estado_s = OCIOSO;
      end
      CALCULA: begin
        if (ultima_s) estado_s = ESCRITA;
        else          estado_s = CALCULA;
      end
      ESCRITA: estado_s = OCIOSO;
      default: estado_s = OCIOSO;
    endcase
  end

  // Operand latch, accumulator and iteration counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_r   <= 2'b00;
      opnd_r <= {WIDTH{1'b0}};
      reg_r  <= {REG_ADDR_W{1'b0}};
      acc_r  <= {(2*WIDTH+1){1'b0}};
      cont_r <= {CW{1'b0}};
    end else if (aceita_s) begin
      op_r   <= operacao;
      opnd_r <= eh_divisao(operacao) ? operandoB : operandoA;
      reg_r  <= regDestino;
      acc_r  <= {{(WIDTH+1){1'b0}}, (eh_divisao(operacao) ? operandoA : operandoB)};
      cont_r <= {CW{1'b0}};
    end else if (estado_r == CALCULA) begin
      acc_r  <= acc_prox_s;
      cont_r <= cont_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cont_r <= cont_r;
    end
  end

  // Next values of the registered outputs; result fields hold between writes
  always_comb begin
    ocupado_s = ocupado_r;
    pronto_s  = 1'b0;
    escreve_s = 1'b0;
    reg_esc_s = reg_esc_r;
    dado_s    = dado_r;
    dz_s      = dz_r;
    case (estado_r)
      OCIOSO: begin
        if (aceita_s) begin
          ocupado_s = 1'b1;
          if (div_zero_in_s) begin
            pronto_s  = 1'b1;
            escreve_s = (regDestino != {REG_ADDR_W{1'b0}});
            reg_esc_s = regDestino;
            dado_s    = operacao[0] ? operandoA : {WIDTH{1'b1}};
            dz_s      = 1'b1;
          end else begin
            pronto_s = 1'b0;
          end
        end else begin
          ocupado_s = 1'b0;
        end
      end
      CALCULA: begin
        if (ultima_s) begin
          pronto_s  = 1'b1;
          escreve_s = (reg_r != {REG_ADDR_W{1'b0}});
          reg_esc_s = reg_r;
          dado_s    = resultado_s;
          dz_s      = 1'b0;
        end else begin
          pronto_s = 1'b0;
        end
      end
      ESCRITA: ocupado_s = 1'b0;
      default: ocupado_s = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
      escreve_r <= 1'b0;
      reg_esc_r <= {REG_ADDR_W{1'b0}};
      dado_r    <= {WIDTH{1'b0}};
      dz_r      <= 1'b0;
    end else begin
      ocupado_r <= ocupado_s;
      pronto_r  <= pronto_s;
      escreve_r <= escreve_s;
      reg_esc_r <= reg_esc_s;
      dado_r    <= dado_s;
      dz_r      <= dz_s;
    end
  end

  assign ocupado     = ocupado_r;
  assign pronto      = pronto_r;
  assign EscreveReg  = escreve_r;
  assign regEscrito  = reg_esc_r;
  assign dadoEscrito = dado_r;
  assign divZero     = dz_r;

endmodule
